elevator_scan_ctrl: RTL and testbench

- Parametrised successor to the team's single-car elevator FSM. Supports N floors, per-floor sticky request latching and SCAN (collective) scheduling: the car keeps travelling in one direction while requests remain ahead of it.
- Adds timed floor-to-floor travel and a timed door-open phase.
- Sits between the hall/car button request logic and the motor/door drivers.

---
 rtl/elevator_scan_if.sv | 35 +++
 rtl/elevator_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_scan_if.sv
// Request/status bundle between button logic, the SCAN controller
// and the motor/door drivers.
interface elevator_scan_if #(
  parameter int NUM_FLOORS = 8
) ();
  localparam int POS_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req;
  logic [POS_W-1:0]      floor_pos;
  logic [NUM_FLOORS-1:0] pending;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic                  arrive;

  modport master (
    output req,
    input  floor_pos,
    input  pending,
    input  moving_up,
    input  moving_down,
    input  door_open,
    input  arrive
  );

  modport slave (
    input  req,
    output floor_pos,
    output pending,
    output moving_up,
    output moving_down,
    output door_open,
    output arrive
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller: sticky requests, SCAN scheduling,
// timed floor travel and door dwell. All outputs registered.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 6
) (
  input logic            clk,
  input logic            reset,
  elevator_scan_if.slave bus
);
  localparam int POS_W = $clog2(NUM_FLOORS);
  localparam int FT_W  = $clog2(FLOOR_TICKS + 1);
  localparam int DT_W  = $clog2(DOOR_TICKS + 1);
  localparam logic [FT_W-1:0] FT_LAST = FT_W'(FLOOR_TICKS - 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DN,
    DOOR
  } state_t;

  state_t                state_q, state_d;
  logic [POS_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FT_W-1:0]       travel_q, travel_d;
  logic [DT_W-1:0]       door_cnt_q, door_cnt_d;
  logic                  last_dir_q, last_dir_d;
  logic                  mv_up_q, mv_up_d;
  logic                  mv_dn_q, mv_dn_d;
  logic                  door_q, door_d;
  logic                  arrive_q, arrive_d;

  logic [NUM_FLOORS-1:0] eff;
  logic [NUM_FLOORS-1:0] above_m;
  logic [NUM_FLOORS-1:0] below_m;
  logic                  above;
  logic                  below;
  logic                  go_fwd;
  logic                  go_rev;
  logic                  go_up;
  logic [POS_W-1:0]      floor_up;
  logic [POS_W-1:0]      floor_dn;

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_m[i] = (i > int'(floor_q));
      below_m[i] = (i < int'(floor_q));
    end
  end

  // last_dir: 1 = up. go_up picks the SCAN direction.
  assign eff      = pending_q | bus.req;
  assign above    = |(eff & above_m);
  assign below    = |(eff & below_m);
  assign go_fwd   = last_dir_q ? above : below;
  assign go_rev   = last_dir_q ? below : above;
  assign go_up    = go_fwd ? last_dir_q : ~last_dir_q;
  assign floor_up = floor_q + 1'b1;
  assign floor_dn = floor_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    pending_d  = eff;
    travel_d   = travel_q;
    door_cnt_d = door_cnt_q;
    last_dir_d = last_dir_q;
    mv_up_d    = 1'b0;
    mv_dn_d    = 1'b0;
    door_d     = 1'b0;
    arrive_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eff[floor_q]) begin
          state_d            = DOOR;
          door_d             = 1'b1;
          arrive_d           = 1'b1;
          door_cnt_d         = '0;
          pending_d[floor_q] = 1'b0;
        end else if (go_fwd || go_rev) begin
          state_d    = go_up ? MOVE_UP : MOVE_DN;
          mv_up_d    = go_up;
          mv_dn_d    = ~go_up;
          last_dir_d = go_up;
          travel_d   = '0;
        end
      end
      MOVE_UP: begin
        if (travel_q != FT_LAST) begin
          travel_d = travel_q + 1'b1;
          mv_up_d  = 1'b1;
        end else begin
          floor_d  = floor_up;
          travel_d = '0;
          if (eff[floor_up]) begin
            state_d             = DOOR;
            door_d              = 1'b1;
            arrive_d            = 1'b1;
            door_cnt_d          = '0;
            pending_d[floor_up] = 1'b0;
          end else begin
            mv_up_d = 1'b1;
          end
        end
      end
      MOVE_DN: begin
        if (travel_q != FT_LAST) begin
          travel_d = travel_q + 1'b1;
          mv_dn_d  = 1'b1;
        end else begin
          floor_d  = floor_dn;
          travel_d = '0;
          if (eff[floor_dn]) begin
            state_d             = DOOR;
            door_d              = 1'b1;
            arrive_d            = 1'b1;
            door_cnt_d          = '0;
            pending_d[floor_dn] = 1'b0;
          end else begin
            mv_dn_d = 1'b1;
          end
        end
      end
      DOOR: begin
        // A call at the open floor holds the door instead of latching.
        pending_d[floor_q] = 1'b0;
        if (bus.req[floor_q]) begin
          door_cnt_d = '0;
          door_d     = 1'b1;
        end else if (door_cnt_q != DT_LAST) begin
          door_cnt_d = door_cnt_q + 1'b1;
          door_d     = 1'b1;
        end else if (go_fwd || go_rev) begin
          state_d    = go_up ? MOVE_UP : MOVE_DN;
          mv_up_d    = go_up;
          mv_dn_d    = ~go_up;
          last_dir_d = go_up;
          travel_d   = '0;
          door_cnt_d = '0;
        end else begin
          state_d    = IDLE;
          door_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      pending_q  <= '0;
      travel_q   <= '0;
      door_cnt_q <= '0;
      last_dir_q <= 1'b1;
      mv_up_q    <= 1'b0;
      mv_dn_q    <= 1'b0;
      door_q     <= 1'b0;
      arrive_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      pending_q  <= pending_d;
      travel_q   <= travel_d;
      door_cnt_q <= door_cnt_d;
      last_dir_q <= last_dir_d;
      mv_up_q    <= mv_up_d;
      mv_dn_q    <= mv_dn_d;
      door_q     <= door_d;
      arrive_q   <= arrive_d;
    end
  end

  assign bus.floor_pos   = floor_q;
  assign bus.pending     = pending_q;
  assign bus.moving_up   = mv_up_q;
  assign bus.moving_down = mv_dn_q;
  assign bus.door_open   = door_q;
  assign bus.arrive      = arrive_q;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl at 8 floors, 4-cycle travel,
// 6-cycle door dwell.
module tb_elevator_scan_ctrl;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  elevator_scan_if #(.NUM_FLOORS(8)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS (8),
    .FLOOR_TICKS(4),
    .DOOR_TICKS (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // {moving_up, moving_down, door_open, arrive, floor_pos}
  logic [6:0] obs;
  assign obs = {bus.moving_up, bus.moving_down, bus.door_open,
                bus.arrive, bus.floor_pos};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_reset();
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({obs, bus.pending} !== 15'b0) begin
      $display("FAIL reset_state obs=%b pend=%b exp=0", obs, bus.pending);
      miscompares++;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 7'b0 || bus.pending !== 8'h00) begin
        $display("FAIL idle_hold c=%0d obs=%b pend=%h exp=0/00",
                 i, obs, bus.pending);
        miscompares++;
      end
    end
  endtask

  task automatic test_travel_top();
    logic [6:0] exp;
    do_reset();
    bus.req = 8'h80;
    @(negedge clk);
    bus.req = '0;
    for (int k = 0; k < 28; k++) begin
      exp = {4'b1000, 3'(k / 4)};
      vectors++;
      if (obs !== exp || bus.pending !== 8'h80) begin
        $display("FAIL travel_up k=%0d obs=%b exp=%b pend=%h exp=80",
                 k, obs, exp, bus.pending);
        miscompares++;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 6; d++) begin
      exp = {3'b001, (d == 0), 3'd7};
      vectors++;
      if (obs !== exp || bus.pending !== 8'h00) begin
        $display("FAIL top_door d=%0d obs=%b exp=%b pend=%h exp=00",
                 d, obs, exp, bus.pending);
        miscompares++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      exp = {4'b0000, 3'd7};
      vectors++;
      if (obs !== exp || bus.pending !== 8'h00) begin
        $display("FAIL top_idle c=%0d obs=%b exp=%b pend=%h",
                 i, obs, exp, bus.pending);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_self_floor();
    logic [6:0] exp;
    do_reset();
    bus.req = 8'h01;
    @(negedge clk);
    bus.req = '0;
    for (int d = 0; d < 6; d++) begin
      exp = {3'b001, (d == 0), 3'd0};
      vectors++;
      if (obs !== exp || bus.pending !== 8'h00) begin
        $display("FAIL self_door d=%0d obs=%b exp=%b pend=%h exp=00",
                 d, obs, exp, bus.pending);
        miscompares++;
      end
      @(negedge clk);
    end
    vectors++;
    if (obs !== 7'b0 || bus.pending !== 8'h00) begin
      $display("FAIL self_idle obs=%b exp=0 pend=%h", obs, bus.pending);
      miscompares++;
    end
  endtask

  task automatic test_scan_reverse();
    logic [6:0] exp;
    logic [7:0] pexp;
    do_reset();
    bus.req = 8'h40;
    @(negedge clk);
    bus.req = '0;
    for (int k = 0; k <= 62; k++) begin
      if (k < 20)      exp = {4'b1000, 3'(k / 4)};
      else if (k < 26) exp = {3'b001, (k == 20), 3'd5};
      else if (k < 30) exp = {4'b1000, 3'd5};
      else if (k < 36) exp = {3'b001, (k == 30), 3'd6};
      else if (k < 56) exp = {4'b0100, 3'(6 - (k - 36) / 4)};
      else if (k < 62) exp = {3'b001, (k == 56), 3'd1};
      else             exp = {4'b0000, 3'd1};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL scan k=%0d obs=%b exp=%b", k, obs, exp);
        miscompares++;
      end
      if (k == 14 || k == 20 || k == 30 || k == 62) begin
        pexp = (k == 14) ? 8'h62 : (k == 20) ? 8'h42 :
               (k == 30) ? 8'h02 : 8'h00;
        vectors++;
        if (bus.pending !== pexp) begin
          $display("FAIL scan_pend k=%0d pend=%h exp=%h",
                   k, bus.pending, pexp);
          miscompares++;
        end
      end
      bus.req = (k == 13) ? 8'h22 : 8'h00;
      if (k < 62) @(negedge clk);
    end
    vectors++;
    if (dut.last_dir_q !== 1'b0) begin
      $display("FAIL scan_last_dir got=%b exp=0 (down)", dut.last_dir_q);
      miscompares++;
    end
  endtask

  task automatic test_door_hold();
    logic [6:0] exp;
    logic [7:0] pexp;
    do_reset();
    bus.req = 8'h04;
    @(negedge clk);
    bus.req = '0;
    for (int k = 0; k <= 18; k++) begin
      if (k < 8)       exp = {4'b1000, 3'(k / 4)};
      else if (k < 18) exp = {3'b001, (k == 8), 3'd2};
      else             exp = {4'b0000, 3'd2};
      pexp = (k < 8) ? 8'h04 : 8'h00;
      vectors++;
      if (obs !== exp || bus.pending !== pexp) begin
        $display("FAIL door_hold k=%0d obs=%b exp=%b pend=%h exp=%h",
                 k, obs, exp, bus.pending, pexp);
        miscompares++;
      end
      bus.req = (k == 11) ? 8'h04 : 8'h00;
      if (k < 18) @(negedge clk);
    end
  endtask

  task automatic test_reset_midmove();
    do_reset();
    bus.req = 8'h40;
    @(negedge clk);
    bus.req = '0;
    repeat (17) @(negedge clk);
    vectors++;
    if (obs !== {4'b1000, 3'd4} || bus.pending !== 8'h40) begin
      $display("FAIL midmove_pre obs=%b exp=1000100 pend=%h exp=40",
               obs, bus.pending);
      miscompares++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (obs !== 7'b0 || bus.pending !== 8'h00) begin
      $display("FAIL async_clear obs=%b pend=%h exp=0/00",
               obs, bus.pending);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 7'b0 || bus.pending !== 8'h00) begin
        $display("FAIL post_reset_idle c=%0d obs=%b pend=%h exp=0/00",
                 i, obs, bus.pending);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.req     = '0;
    test_reset();
    test_travel_top();
    test_self_floor();
    test_scan_reverse();
    test_door_hold();
    test_reset_midmove();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
